// File: rtl/clk_tick_pkg.sv
// Shared constants for the tick generator: 100 MHz system clock and the standard
// divisors for the 1 kHz display scan and 2 Hz counter timebase.
package clk_tick_pkg;

    localparam int          DEF_CNT_W   = 32;
    localparam int unsigned SYS_CLK_HZ  = 100_000_000;
    localparam int unsigned DIV_SCAN_1K = 50_000;
    localparam int unsigned DIV_CNT_2HZ = 25_000_000;

    // Divisor for a square output of frequency hz (sq toggles once per tick).
    function automatic int unsigned hz_to_div(input int unsigned hz);
        return SYS_CLK_HZ / (2 * hz);
    endfunction

endpackage

// File: rtl/tick_div_ch.sv
// One rate channel: programmable divider with a shadow divisor that is applied
// on the channel's own wrap (or on sync), so a period is never cut short.
module tick_div_ch
    import clk_tick_pkg::*;
#(
    parameter int               CNT_W    = DEF_CNT_W,
    parameter logic [CNT_W-1:0] DIV_INIT = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_run,
    input  logic             i_sync,
    input  logic             i_we,
    input  logic [CNT_W-1:0] i_div,
    output logic             o_tick,
    output logic             o_sq,
    output logic             o_pend
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div_act;
    logic [CNT_W-1:0] r_div_shd;
    logic             r_tick;
    logic             r_sq;
    logic             r_pend;

    logic w_div_le1;
    logic w_wrap;
    logic w_apply;

    // Divisors 0 and 1 both mean divide-by-1; decoding them first keeps the
    // (div-1) compare free of the underflowed value.
    assign w_div_le1 = (r_div_act <= CNT_W'(1));
    assign w_wrap    = i_run && (w_div_le1 || (r_cnt == r_div_act - CNT_W'(1)));
    assign w_apply   = r_pend && (i_sync || w_wrap);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt     <= '0;
            r_div_act <= DIV_INIT;
            r_div_shd <= DIV_INIT;
            r_tick    <= 1'b0;
            r_sq      <= 1'b0;
            r_pend    <= 1'b0;
        end else begin
            if (i_sync) begin
                r_cnt  <= '0;
                r_sq   <= 1'b0;
                r_tick <= 1'b0;
            end else if (w_wrap) begin
                r_cnt  <= '0;
                r_tick <= 1'b1;
                r_sq   <= ~r_sq;
            end else begin
                r_tick <= 1'b0;
                if (i_run)
                    r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_apply) begin
                r_div_act <= r_div_shd;
                r_pend    <= 1'b0;
            end
            // A write on the apply edge lands after the old shadow moved over.
            if (i_we) begin
                r_div_shd <= i_div;
                r_pend    <= 1'b1;
            end
        end
    end

    assign o_tick = r_tick;
    assign o_sq   = r_sq;
    assign o_pend = r_pend;

endmodule

// File: rtl/clk_tick_gen.sv
// Multi-channel tick / square-wave rate generator with runtime divisors.
// Define CLK_TICK_GATE_EN to add per-channel run enables (i_ch_en).
module clk_tick_gen
    import clk_tick_pkg::*;
#(
    parameter int                        NUM_CH  = 2,
    parameter int                        CNT_W   = DEF_CNT_W,
    parameter logic [NUM_CH*CNT_W-1:0]   DIV_RST = {32'd25_000_000, 32'd50_000},
    localparam int                       CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_sync,
    input  logic              i_cfg_we,
    input  logic [CH_W-1:0]   i_cfg_ch,
    input  logic [CNT_W-1:0]  i_cfg_div,
`ifdef CLK_TICK_GATE_EN
    input  logic [NUM_CH-1:0] i_ch_en,
`endif
    output logic [NUM_CH-1:0] o_tick,
    output logic [NUM_CH-1:0] o_sq,
    output logic [NUM_CH-1:0] o_cfg_pend
);

    logic [NUM_CH-1:0] w_we;
    logic [NUM_CH-1:0] w_run;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            // Out-of-range channel indices match no instance and are dropped.
            assign w_we[g] = i_cfg_we && (int'(i_cfg_ch) == g);
`ifdef CLK_TICK_GATE_EN
            assign w_run[g] = i_en && i_ch_en[g];
`else
            assign w_run[g] = i_en;
`endif
            tick_div_ch #(
                .CNT_W    (CNT_W),
                .DIV_INIT (DIV_RST[g*CNT_W +: CNT_W])
            ) u_ch (
                .i_clk  (i_clk),
                .i_rst  (i_rst),
                .i_run  (w_run[g]),
                .i_sync (i_sync),
                .i_we   (w_we[g]),
                .i_div  (i_cfg_div),
                .o_tick (o_tick[g]),
                .o_sq   (o_sq[g]),
                .o_pend (o_cfg_pend[g])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clk_tick_gen.sv
// Bench for clk_tick_gen: reset/free-run vector table, directed corner sequences,
// then randomized traffic against a period-counting reference model.
module tb_clk_tick_gen;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 32;
    localparam int CH_W   = 2;
    localparam logic [NUM_CH*CNT_W-1:0] DIV_RST = {32'd7, 32'd10, 32'd4};

    typedef struct {
        logic              en;
        logic [NUM_CH-1:0] tick;
        logic [NUM_CH-1:0] sq;
        logic [NUM_CH-1:0] pend;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst, en, sync, cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic [NUM_CH-1:0] ch_en;
    logic [NUM_CH-1:0] tick, sq, cfg_pend;

    int n_cmp = 0;
    int n_bad = 0;

    int unsigned rst_div [NUM_CH] = '{4, 10, 7};
    int unsigned m_act   [NUM_CH];
    int unsigned m_shd   [NUM_CH];
    int unsigned m_el    [NUM_CH];
    int unsigned m_nt    [NUM_CH];
    bit          m_pend  [NUM_CH];
    bit          m_tick  [NUM_CH];

    always #5 clk = ~clk;

    clk_tick_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DIV_RST(DIV_RST)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_en       (en),
        .i_sync     (sync),
        .i_cfg_we   (cfg_we),
        .i_cfg_ch   (cfg_ch),
        .i_cfg_div  (cfg_div),
`ifdef CLK_TICK_GATE_EN
        .i_ch_en    (ch_en),
`endif
        .o_tick     (tick),
        .o_sq       (sq),
        .o_cfg_pend (cfg_pend)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: each channel counts elapsed run cycles; a period of max(div,1)
    // completed means a tick, and sq is the parity of ticks since reset/sync.
    task automatic model_step();
        for (int c = 0; c < NUM_CH; c++) begin
            bit apply;
            bit run;
            int unsigned per;
            apply = 0;
            run   = en;
`ifdef CLK_TICK_GATE_EN
            run   = en && ch_en[c];
`endif
            if (rst) begin
                m_act[c] = rst_div[c]; m_shd[c] = rst_div[c];
                m_el[c] = 0; m_nt[c] = 0; m_pend[c] = 0; m_tick[c] = 0;
            end else begin
                if (sync) begin
                    m_el[c] = 0; m_nt[c] = 0; m_tick[c] = 0;
                    apply = m_pend[c];
                end else if (run) begin
                    per = (m_act[c] < 2) ? 1 : m_act[c];
                    m_el[c]++;
                    if (m_el[c] >= per) begin
                        m_el[c] = 0; m_nt[c]++; m_tick[c] = 1;
                        apply = m_pend[c];
                    end else begin
                        m_tick[c] = 0;
                    end
                end else begin
                    m_tick[c] = 0;
                end
                if (apply) begin
                    m_act[c] = m_shd[c]; m_pend[c] = 0;
                end
                if (cfg_we && int'(cfg_ch) == c) begin
                    m_shd[c] = cfg_div; m_pend[c] = 1;
                end
            end
        end
    endtask

    task automatic step();
        logic [NUM_CH-1:0] et, es, ep;
        @(posedge clk);
        #1;
        model_step();
        for (int c = 0; c < NUM_CH; c++) begin
            et[c] = m_tick[c];
            es[c] = m_nt[c][0];
            ep[c] = m_pend[c];
        end
        check("model_tick", tick, et);
        check("model_sq", sq, es);
        check("model_pend", cfg_pend, ep);
    endtask

    // Steps until tick[c] rises; returns 99 if the budget runs out.
    task automatic wait_tick(input int c, input int budget, output int n);
        n = 99;
        for (int s = 1; s <= budget; s++) begin
            step();
            if (tick[c]) begin
                n = s;
                break;
            end
        end
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [20];
        int   n;
        logic sq_hold;

        rst = 1; en = 0; sync = 0; cfg_we = 0; cfg_ch = '0; cfg_div = '0; ch_en = '1;
        step(); step();
        check("rst_tick", tick, 0);
        check("rst_sq", sq, 0);
        check("rst_pend", cfg_pend, 0);

        // Free run from reset: tick every div cycles, sq flips per tick.
        for (int k = 1; k <= 20; k++) begin
            vt[k-1].en   = 1'b1;
            vt[k-1].pend = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                vt[k-1].tick[c] = (k % rst_div[c]) == 0;
                vt[k-1].sq[c]   = ((k / rst_div[c]) % 2) == 1;
            end
        end
        rst = 0;
        foreach (vt[i]) begin
            en = vt[i].en;
            step();
            check("tbl_tick", tick, vt[i].tick);
            check("tbl_sq", sq, vt[i].sq);
            check("tbl_pend", cfg_pend, vt[i].pend);
        end

        // Pause at ch0 cnt=2: hold, then tick two cycles after resume.
        step(); step();
        sq_hold = sq[0];
        en = 0;
        repeat (3) begin
            step();
            check("pause_tick", tick, 0);
            check("pause_sq0", sq[0], sq_hold);
        end
        en = 1;
        step();
        check("resume_1", tick[0], 0);
        step();
        check("resume_2", tick[0], 1);

        // Mid-count divisor write: current period stays 4, then 6.
        step(); step();
        cfg_we = 1; cfg_ch = 0; cfg_div = 6;
        step();
        cfg_we = 0;
        check("wr_pend_set", cfg_pend[0], 1);
        check("wr_no_tick", tick[0], 0);
        step();
        check("wr_old_period", tick[0], 1);
        check("wr_pend_clr", cfg_pend[0], 0);
        wait_tick(0, 12, n);
        check("wr_new_period_a", n, 6);
        wait_tick(0, 12, n);
        check("wr_new_period_b", n, 6);

        // Restore ch0=4, run 13 cycles, then sync re-phases everything.
        cfg_we = 1; cfg_ch = 0; cfg_div = 4;
        step();
        cfg_we = 0;
        repeat (12) step();
        sync = 1;
        step();
        sync = 0;
        check("sync_tick", tick, 0);
        check("sync_sq", sq, 0);
        check("sync_pend", cfg_pend, 0);
        for (int s = 1; s <= 20; s++) begin
            step();
            check("sync_t0", tick[0], (s % 4) == 0);
            check("sync_t1", tick[1], (s % 10) == 0);
        end

        // Write together with sync stays pending until the next wrap.
        cfg_we = 1; cfg_ch = 1; cfg_div = 3; sync = 1;
        step();
        cfg_we = 0; sync = 0;
        check("syncwr_pend", cfg_pend[1], 1);
        wait_tick(1, 14, n);
        check("syncwr_old", n, 10);
        wait_tick(1, 14, n);
        check("syncwr_new", n, 3);

        // Divisor 0 then 1 on ch1: tick every enabled cycle.
        for (int d = 0; d < 2; d++) begin
            cfg_we = 1; cfg_ch = 1; cfg_div = d;
            step();
            cfg_we = 0; sync = 1;
            step();
            sync = 0;
            for (int s = 1; s <= 5; s++) begin
                step();
                check("div01_tick", tick[1], 1);
                check("div01_sq", sq[1], s % 2);
            end
            en = 0;
            step();
            check("div01_off", tick[1], 0);
            en = 1;
        end

        // Out-of-range channel index is ignored.
        cfg_we = 1; cfg_ch = 3; cfg_div = 5;
        step();
        cfg_we = 0;
        check("bad_ch_pend", cfg_pend, 0);

`ifdef CLK_TICK_GATE_EN
        ch_en = 3'b101;
        sq_hold = sq[1];
        repeat (12) begin
            step();
            check("gate_t1", tick[1], 0);
            check("gate_sq1", sq[1], sq_hold);
        end
        ch_en = '1;
`endif

        for (int i = 0; i < 800; i++) begin
            en      = ($urandom_range(0, 9) != 0);
            sync    = ($urandom_range(0, 39) == 0);
            cfg_we  = ($urandom_range(0, 7) == 0);
            cfg_ch  = CH_W'($urandom_range(0, 3));
            cfg_div = $urandom_range(0, 12);
            ch_en   = ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom) : '1;
            step();
        end
        en = 1; sync = 0; cfg_we = 0; ch_en = '1;
        repeat (5) step();

        rst = 1;
        step();
        rst = 0;
        check("rst_mid_tick", tick, 0);
        check("rst_mid_sq", sq, 0);
        check("rst_mid_pend", cfg_pend, 0);
        wait_tick(0, 8, n);
        check("rst_mid_first", n, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
